// File: rtl/muldiv_pkg.sv
// Shared encodings and sizing for the execute-stage multiply/divide unit.
// The DIV state exists only when MULDIV_DIV_EN is defined.
package muldiv_pkg;

    localparam int WIDTH = 32;
    localparam int ITER  = 32;
    localparam int CNT_W = $clog2(ITER);

    localparam logic [2:0] OP_MULT  = 3'b000;
    localparam logic [2:0] OP_MULTU = 3'b001;
    localparam logic [2:0] OP_DIV   = 3'b010;
    localparam logic [2:0] OP_DIVU  = 3'b011;
    localparam logic [2:0] OP_MTHI  = 3'b100;
    localparam logic [2:0] OP_MTLO  = 3'b101;

`ifdef MULDIV_DIV_EN
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_MUL   = 2'd1,
        ST_DIV   = 2'd2,
        ST_FIXUP = 2'd3
    } state_e;
`else
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_MUL   = 2'd1,
        ST_FIXUP = 2'd3
    } state_e;
`endif

    // Magnitude of a two's-complement operand; 0x80000000 maps to itself,
    // which is the correct unsigned magnitude.
    function automatic logic [WIDTH-1:0] abs_val(input logic [WIDTH-1:0] v,
                                                 input logic             is_signed);
        return (is_signed && v[WIDTH-1]) ? -v : v;
    endfunction

endpackage

// File: rtl/div_restore_step.sv
// One restoring-division iteration: shift in the next dividend bit, trial-subtract
// the divisor, keep the difference when it does not borrow.
module div_restore_step
    import muldiv_pkg::*;
(
    input  logic [WIDTH-1:0] rem_i,
    input  logic             dividend_bit_i,
    input  logic [WIDTH-1:0] divisor_i,
    output logic [WIDTH-1:0] rem_o,
    output logic             q_bit_o
);

    logic [WIDTH:0] shifted;
    logic [WIDTH:0] diff;

    // rem_i < divisor_i always holds, so bit WIDTH of diff is exactly the borrow.
    assign shifted = {rem_i, dividend_bit_i};
    assign diff    = shifted - {1'b0, divisor_i};
    assign q_bit_o = ~diff[WIDTH];
    assign rem_o   = q_bit_o ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];

endmodule

// File: rtl/execute_muldiv.sv
// Iterative HI/LO multiply-divide unit for the execute stage (shift-add multiply,
// restoring divide). Divide support is compiled in only when MULDIV_DIV_EN is defined.
//   state    | meaning
//   ST_IDLE  | accepting Start; MTHI/MTLO and divide-by-zero complete here
//   ST_MUL   | 32 shift-add steps on operand magnitudes
//   ST_DIV   | 32 restoring-division steps (MULDIV_DIV_EN only)
//   ST_FIXUP | sign correction, HI/LO write, Done pulse
module execute_muldiv
    import muldiv_pkg::*;
(
    input  logic             Clock,
    input  logic             Reset,
    input  logic             Start,
    input  logic [2:0]       Op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             Busy,
    output logic             Done,
    output logic             DivByZero,
    output logic [WIDTH-1:0] Hi,
    output logic [WIDTH-1:0] Lo
);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   opnd_q, opnd_d;
    logic               neg_res_q, neg_res_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic               done_q, done_d;
`ifdef MULDIV_DIV_EN
    logic               is_div_q, is_div_d;
    logic               neg_rem_q, neg_rem_d;
    logic               dbz_q, dbz_d;
`endif

    logic               op_signed;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH-1:0]   step_rem;
    logic               step_qbit;

    assign op_signed = ~Op[0];
    assign mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, opnd_q};

    // For divide, acc holds {partial remainder, dividend/quotient shift register}.
    div_restore_step u_step (
        .rem_i          (acc_q[2*WIDTH-1:WIDTH]),
        .dividend_bit_i (acc_q[WIDTH-1]),
        .divisor_i      (opnd_q),
        .rem_o          (step_rem),
        .q_bit_o        (step_qbit)
    );

`ifndef MULDIV_DIV_EN
    logic div_step_unused;
    assign div_step_unused = ^{step_rem, step_qbit};
`endif

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        opnd_d    = opnd_q;
        neg_res_d = neg_res_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        done_d    = 1'b0;
`ifdef MULDIV_DIV_EN
        is_div_d  = is_div_q;
        neg_rem_d = neg_rem_q;
        dbz_d     = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                if (Start) begin
                    case (Op)
                        OP_MULT, OP_MULTU: begin
                            acc_d     = {{WIDTH{1'b0}}, abs_val(B, op_signed)};
                            opnd_d    = abs_val(A, op_signed);
                            neg_res_d = op_signed & (A[WIDTH-1] ^ B[WIDTH-1]);
                            cnt_d     = CNT_W'(ITER - 1);
                            state_d   = ST_MUL;
`ifdef MULDIV_DIV_EN
                            is_div_d  = 1'b0;
`endif
                        end
`ifdef MULDIV_DIV_EN
                        OP_DIV, OP_DIVU: begin
                            if (B == '0) begin
                                done_d = 1'b1;
                                dbz_d  = 1'b1;
                            end else begin
                                acc_d     = {{WIDTH{1'b0}}, abs_val(A, op_signed)};
                                opnd_d    = abs_val(B, op_signed);
                                neg_res_d = op_signed & (A[WIDTH-1] ^ B[WIDTH-1]);
                                neg_rem_d = op_signed & A[WIDTH-1];
                                cnt_d     = CNT_W'(ITER - 1);
                                is_div_d  = 1'b1;
                                state_d   = ST_DIV;
                            end
                        end
`endif
                        OP_MTHI: begin
                            hi_d   = A;
                            done_d = 1'b1;
                        end
                        OP_MTLO: begin
                            lo_d   = A;
                            done_d = 1'b1;
                        end
                        default: ;
                    endcase
                end
            end
            ST_MUL: begin
                acc_d = acc_q[0] ? {mul_sum, acc_q[WIDTH-1:1]}
                                 : {1'b0, acc_q[2*WIDTH-1:1]};
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == '0) state_d = ST_FIXUP;
            end
`ifdef MULDIV_DIV_EN
            ST_DIV: begin
                acc_d = {step_rem, acc_q[WIDTH-2:0], step_qbit};
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == '0) state_d = ST_FIXUP;
            end
`endif
            ST_FIXUP: begin
`ifdef MULDIV_DIV_EN
                if (is_div_q) begin
                    lo_d = neg_res_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
                    hi_d = neg_rem_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
                end else begin
                    {hi_d, lo_d} = neg_res_q ? -acc_q : acc_q;
                end
`else
                {hi_d, lo_d} = neg_res_q ? -acc_q : acc_q;
`endif
                done_d  = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (!Reset) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            acc_q     <= '0;
            opnd_q    <= '0;
            neg_res_q <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
            done_q    <= 1'b0;
`ifdef MULDIV_DIV_EN
            is_div_q  <= 1'b0;
            neg_rem_q <= 1'b0;
            dbz_q     <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            opnd_q    <= opnd_d;
            neg_res_q <= neg_res_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            done_q    <= done_d;
`ifdef MULDIV_DIV_EN
            is_div_q  <= is_div_d;
            neg_rem_q <= neg_rem_d;
            dbz_q     <= dbz_d;
`endif
        end
    end

    assign Busy = (state_q != ST_IDLE);
    assign Done = done_q;
    assign Hi   = hi_q;
    assign Lo   = lo_q;
`ifdef MULDIV_DIV_EN
    assign DivByZero = dbz_q;
`else
    assign DivByZero = 1'b0;
`endif

endmodule

// File: doc/execute_muldiv.md
EXECUTE_MULDIV -- requirements
Module: execute_muldiv

Interface
REQ-001 SHALL provide port: Clock  input  1  pipeline clock; all state updates on rising edge.
REQ-002 SHALL provide port: Reset  input  1  reset; one clock; reset is synchronous and active-low.
REQ-003 SHALL provide port: Start  input  1  operation request from the Decode/Execute register outputs.
REQ-004 SHALL provide port: Op  input  3  000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO, 11x no-op.
REQ-005 SHALL provide port: A  input  32  rs operand (dividend / multiplicand / MTHI-MTLO data).
REQ-006 SHALL provide port: B  input  32  rt operand (divisor / multiplier).
REQ-007 SHALL provide port: Busy  output  1  high while an iterative operation is in flight; drives the Decode stall.
REQ-008 SHALL provide port: Done  output  1  registered, one-cycle completion pulse.
REQ-009 SHALL provide port: DivByZero  output  1  registered, one-cycle pulse on divide with B==0.
REQ-010 SHALL provide port: Hi  output  32  architectural HI register, for MFHI.
REQ-011 SHALL provide port: Lo  output  32  architectural LO register, for MFLO.

Function
REQ-012 SHALL implement a state machine with states IDLE, MUL, DIV, FIXUP; Busy = (state != IDLE).
REQ-013 SHALL accept Start only in IDLE; Start while Busy SHALL be ignored with no state change.
REQ-014 MULT/MULTU accepted at edge t: MUL for 32 cycles (shift-add, 5-bit counter 31->0), FIXUP 1 cycle, back to IDLE at edge t+33, with Hi/Lo updated and Done=1 for that one cycle.
REQ-015 DIV/DIVU with B!=0: DIV for 32 cycles (restoring, one quotient bit per cycle), FIXUP 1 cycle, completion timing identical to REQ-014.
REQ-016 Signed ops SHALL operate on magnitudes and apply sign correction in FIXUP: product sign = A[31]^B[31]; quotient truncates toward zero; remainder takes the dividend's sign.
REQ-017 Results SHALL be: multiply -> {Hi,Lo} = 64-bit product; divide -> Lo = quotient, Hi = remainder.
REQ-018 DIV 0x80000000 / 0xFFFFFFFF SHALL yield Lo=0x80000000, Hi=0x00000000, with no error.
REQ-019 DIV/DIVU with B==0 SHALL not enter DIV: at edge t+1 Done=1, DivByZero=1, Hi/Lo unchanged, Busy never asserted.
REQ-020 MTHI/MTLO SHALL write A into Hi/Lo at edge t with Done=1 in the following cycle and Busy never asserted.
REQ-021 Op 11x with Start SHALL be ignored: no Done, no Busy.
REQ-022 Operands SHALL be latched at acceptance; A/B changes during Busy SHALL have no effect.
REQ-023 Hi/Lo SHALL be modified only at completion or MTHI/MTLO, never mid-iteration.

Reset
REQ-024 Reset==0 at an edge SHALL force state IDLE, counter 0, Hi=Lo=0, Busy=Done=DivByZero=0, and abort any in-flight operation.
REQ-025 Start sampled in the same cycle as Reset==0 SHALL be discarded.

Configuration
REQ-026 Macro MULDIV_DIV_EN defined SHALL compile in the DIV state, the divider datapath and DivByZero behaviour.
REQ-027 Without MULDIV_DIV_EN, DIV/DIVU SHALL be treated as REQ-021 no-ops, DivByZero SHALL be tied 0, and the DIV state SHALL be absent.

Structure
REQ-028 Package muldiv_pkg SHALL hold the Op encodings, the state encoding, and the constants WIDTH=32 and ITER=32.
REQ-029 The single restoring-division step (partial remainder, divisor -> next remainder, quotient bit) SHALL be one combinational sub-module, div_restore_step.

Verification
REQ-030 Bench SHALL check: MULTU A=B=0xFFFFFFFF -> Busy 33 cycles, then Hi=0xFFFFFFFE, Lo=0x00000001, Done one cycle.
REQ-031 Bench SHALL check: MULT A=0xFFFFFFFD (-3), B=7 -> Hi=0xFFFFFFFF, Lo=0xFFFFFFEB at edge t+33.
REQ-032 Bench SHALL check: DIV A=-7, B=2 -> Lo=0xFFFFFFFD, Hi=0xFFFFFFFF; DIVU A=100, B=7 -> Lo=14, Hi=2.
REQ-033 Bench SHALL check: DIV with B=0 after Hi=Lo=0x55 -> at t+1 Done=DivByZero=1, Hi/Lo still 0x55, Busy=0.
REQ-034 Bench SHALL check: MTHI 0x12345678 -> Hi=0x12345678 next cycle; second Start during an active MULT ignored, Hi/Lo reflect the first op only.
REQ-035 Bench SHALL check: Reset=0 at cycle 10 of a MULT -> next cycle Busy=0, Hi=Lo=0, no Done ever pulses for the aborted op.
